// File: rtl/dmem_responder_if.sv
// Request/response bus between the load/store unit (initiator) and the
// data-memory responder. The initiator drives the request and accepts the
// response; the responder does the opposite.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store at a time,
// waits LATENCY cycles, performs the access, then holds the response until
// the initiator takes it. Doublewords 0..3 are exposed as debug taps.
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,   // active-low, synchronous
    dmem_responder_if.slave   bus,
    output logic              busy,
    output logic [63:0]       mem0,
    output logic [63:0]       mem1,
    output logic [63:0]       mem2,
    output logic [63:0]       mem3
);
    localparam int AW = $clog2(DEPTH);
    // Counter only needs to hold LATENCY-1; keep at least one bit.
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic           write_q;
    logic [63:0]    addr_q;
    logic [63:0]    wdata_q;
    logic           req_ready_q;
    logic           resp_valid_q;
    logic [63:0]    resp_rdata_q;
    logic           resp_err_q;
    logic [63:0]    mem_q [DEPTH];

    // Decode of the latched address; only consumed on the WAIT->RESP edge.
    logic [AW-1:0]  acc_index_d;
    logic           acc_err_d;

    // Word index and error flag (misaligned or beyond the last doubleword).
    always_comb begin
        acc_index_d = addr_q[AW+2:3];
        acc_err_d   = (addr_q[2:0] != 3'b000) || (addr_q[63:AW+3] != '0);
    end

    // Transaction FSM with registered handshake outputs and the storage array.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        write_q     <= bus.req_write;
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        cnt_q       <= CNT_INIT;
                        req_ready_q <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        if (acc_err_d) begin
                            // Faulting accesses never touch storage.
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else if (write_q) begin
                            mem_q[acc_index_d] <= wdata_q;
                            resp_err_q   <= 1'b0;
                            resp_rdata_q <= '0;
                        end else begin
                            resp_err_q   <= 1'b0;
                            resp_rdata_q <= mem_q[acc_index_d];
                        end
                    end
                end
                RESP: begin
                    // req_ready comes back only after the handshake edge, so a
                    // new request can never overlap the response handshake.
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    assign busy = (state_q != IDLE);
    assign mem0 = mem_q[0];
    assign mem1 = mem_q[1];
    assign mem2 = mem_q[2];
    assign mem3 = mem_q[3];
endmodule
